mgt01_freg_file_ctx: RTL and testbench

- Parametrised floating-point register file for the next MicroGT core generation.
- Configurable data width, depth and number of combinational read ports; single write port with optional write-to-read bypass.
- Replaces one-cycle whole-file load/store with a streaming context save/restore engine: one register per beat over valid/ready, with per-register dirty tracking so a save can skip unmodified registers.
- Sits between the FP pipeline (read/write ports) and the context-switch/trap unit (save/restore streams).

---
 rtl/mgt01_freg_file_ctx.sv | 190 +++++++++++++++++++
 tb/tb_mgt01_freg_file_ctx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgt01_freg_file_ctx.sv
// Purpose: FP register file with N_RD combinational read ports, one write port, and a streaming context save/restore engine with per-register dirty tracking.
// Latency: reads are combinational (optional same-cycle write bypass); writes land on the next rising edge; save/restore move one register per handshake.
// Backpressure: save beats hold valid/addr/data until sv_ready_i; restore accepts a beat whenever rs_valid_i is high; pipeline writes made while busy are dropped and flagged.
module mgt01_freg_file_ctx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int N_RD   = 3,
  parameter bit BYPASS = 1'b1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_en_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        w_addr_i,
  input  logic [DATA_W-1:0]        w_data_i,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [N_RD*DATA_W-1:0]   rd_data_o,
  input  logic                     save_start_i,
  input  logic                     save_dirty_only_i,
  input  logic                     restore_start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     wr_drop_o,
  output logic                     sv_valid_o,
  input  logic                     sv_ready_i,
  output logic [ADDR_W-1:0]        sv_addr_o,
  output logic [DATA_W-1:0]        sv_data_o,
  output logic                     sv_last_o,
  input  logic                     rs_valid_i,
  output logic                     rs_ready_o,
  input  logic [DATA_W-1:0]        rs_data_i,
  output logic [DEPTH-1:0]         dirty_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
  logic                r_dirty_only, w_dirty_only_nxt;
  logic                r_done, w_done_nxt;
  logic                r_wr_drop;
  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [DEPTH-1:0]    r_dirty;

  logic                w_ptr_last;
  logic                w_higher_dirty;
  logic                w_wr_acc;
  logic                w_sv_valid;
  logic                w_sv_last;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;
  logic                w_dirty_set;
  logic                w_dirty_clr;

  assign w_ptr_last  = (r_ptr == ADDR_W'(DEPTH - 1));
  // A pipeline write only takes effect in IDLE on an enabled edge.
  assign w_wr_acc    = clk_en_i && we_i && (r_state == ST_IDLE);
  assign w_dirty_set = we_i && (r_state == ST_IDLE);
  assign w_sv_valid  = (r_state == ST_SAVE) && (!r_dirty_only || r_dirty[r_ptr]);
  assign w_sv_last   = w_sv_valid && (r_dirty_only ? !w_higher_dirty : w_ptr_last);

  // Any dirty register above the pointer means the current dirty-only beat is not the last.
  always_comb begin
    w_higher_dirty = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i > int'(r_ptr)) && r_dirty[i]) w_higher_dirty = 1'b1;
    end
  end

  // Combinational read ports, with same-cycle forwarding of an accepted write.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < N_RD; k++) begin
      if (BYPASS && w_wr_acc && (rd_addr_i[k*ADDR_W +: ADDR_W] == w_addr_i))
        rd_data_o[k*DATA_W +: DATA_W] = w_data_i;
      else
        rd_data_o[k*DATA_W +: DATA_W] = r_regs[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

  // FSM next-state, pointer and storage-write selection.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_dirty_only_nxt = r_dirty_only;
    w_done_nxt       = 1'b0;
    w_mem_we         = 1'b0;
    w_mem_addr       = w_addr_i;
    w_mem_data       = w_data_i;
    w_dirty_clr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_mem_we = we_i;
        if (save_start_i) begin
          w_state_nxt      = ST_SAVE;
          w_ptr_nxt        = '0;
          w_dirty_only_nxt = save_dirty_only_i;
        end else if (restore_start_i) begin
          w_state_nxt = ST_RESTORE;
          w_ptr_nxt   = '0;
        end
      end
      ST_SAVE: begin
        if (w_sv_valid) begin
          if (sv_ready_i) begin
            w_dirty_clr = 1'b1;
            if (w_sv_last) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_ptr_nxt = r_ptr + ADDR_W'(1);
            end
          end
        end else if (w_ptr_last) begin
          // Dirty-only scan reached the top without anything left to send.
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      ST_RESTORE: begin
        w_mem_addr = r_ptr;
        w_mem_data = rs_data_i;
        if (rs_valid_i) begin
          w_mem_we    = 1'b1;
          w_dirty_clr = 1'b1;
          if (w_ptr_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + ADDR_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, pointer and single-cycle status pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_dirty_only <= 1'b0;
      r_done       <= 1'b0;
      r_wr_drop    <= 1'b0;
    end else if (clk_en_i) begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_dirty_only <= w_dirty_only_nxt;
      r_done       <= w_done_nxt;
      r_wr_drop    <= we_i && (r_state != ST_IDLE);
    end
  end

  // Register storage, written by the pipeline in IDLE or by restore beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (clk_en_i && w_mem_we) begin
      r_regs[w_mem_addr] <= w_mem_data;
    end
  end

  // Dirty bits: set by pipeline writes, cleared by save handshakes and restore beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dirty <= '0;
    end else if (clk_en_i) begin
      if (w_dirty_set) r_dirty[w_addr_i] <= 1'b1;
      if (w_dirty_clr) r_dirty[r_ptr]    <= 1'b0;
    end
  end

  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = r_done;
  assign wr_drop_o  = r_wr_drop;
  assign sv_valid_o = w_sv_valid;
  assign sv_last_o  = w_sv_last;
  assign sv_addr_o  = r_ptr;
  assign sv_data_o  = r_regs[r_ptr];
  assign rs_ready_o = (r_state == ST_RESTORE);
  assign dirty_o    = r_dirty;

endmodule

// File: tb/tb_mgt01_freg_file_ctx.sv
// Purpose: randomized self-checking bench for mgt01_freg_file_ctx against an array/queue reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later.
// Backpressure: save ready is held, toggled or randomized; restore valid has random gaps.
module tb_mgt01_freg_file_ctx;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int N_RD   = 3;
  localparam int ADDR_W = 5;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   clk_en_i;
  logic                   we_i;
  logic [ADDR_W-1:0]      w_addr_i;
  logic [DATA_W-1:0]      w_data_i;
  logic [N_RD*ADDR_W-1:0] rd_addr_i;
  logic [N_RD*DATA_W-1:0] rd_data_o;
  logic                   save_start_i;
  logic                   save_dirty_only_i;
  logic                   restore_start_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   wr_drop_o;
  logic                   sv_valid_o;
  logic                   sv_ready_i;
  logic [ADDR_W-1:0]      sv_addr_o;
  logic [DATA_W-1:0]      sv_data_o;
  logic                   sv_last_o;
  logic                   rs_valid_i;
  logic                   rs_ready_o;
  logic [DATA_W-1:0]      rs_data_i;
  logic [DEPTH-1:0]       dirty_o;

  always #5 clk_i = ~clk_i;

  mgt01_freg_file_ctx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_RD(N_RD), .BYPASS(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
    .we_i(we_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .save_start_i(save_start_i), .save_dirty_only_i(save_dirty_only_i),
    .restore_start_i(restore_start_i), .busy_o(busy_o), .done_o(done_o),
    .wr_drop_o(wr_drop_o), .sv_valid_o(sv_valid_o), .sv_ready_i(sv_ready_i),
    .sv_addr_o(sv_addr_o), .sv_data_o(sv_data_o), .sv_last_o(sv_last_o),
    .rs_valid_i(rs_valid_i), .rs_ready_o(rs_ready_o), .rs_data_i(rs_data_i),
    .dirty_o(dirty_o)
  );

  // Reference model: register contents and dirty flags.
  logic [DATA_W-1:0] m_regs [DEPTH];
  logic [DEPTH-1:0]  m_dirty;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_dirty = '0;
  endtask

  // One IDLE cycle: optional write plus a read on every port (ra_force < 0 = random addresses).
  task automatic rw_cycle(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                          input int ra_force);
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] exp;
    @(negedge clk_i);
    we_i = we; w_addr_i = wa; w_data_i = wd;
    for (int k = 0; k < N_RD; k++)
      rd_addr_i[k*ADDR_W +: ADDR_W] = (ra_force < 0) ? ADDR_W'($urandom_range(0, DEPTH-1)) : ADDR_W'(ra_force);
    #1;
    for (int k = 0; k < N_RD; k++) begin
      ra  = rd_addr_i[k*ADDR_W +: ADDR_W];
      exp = (we && ra == wa) ? wd : m_regs[ra];
      check("rd_port", rd_data_o[k*DATA_W +: DATA_W], exp);
    end
    if (we) begin
      m_regs[wa]  = wd;
      m_dirty[wa] = 1'b1;
    end
  endtask

  // Save: rmode 0 = ready held high, 1 = ready toggles 1,0,..., 2 = random ready.
  task automatic do_save(input bit donly, input int rmode, input string tag);
    int exp_q[$];
    int n_exp;
    int beats = 0;
    int cyc = 0;
    int a;
    bit stalled = 0;
    logic rdy;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_data;
    for (int i = 0; i < DEPTH; i++) if (!donly || m_dirty[i]) exp_q.push_back(i);
    n_exp = exp_q.size();
    @(negedge clk_i);
    we_i = 0; sv_ready_i = 0; save_start_i = 1; save_dirty_only_i = donly;
    @(negedge clk_i);
    save_start_i = 0; save_dirty_only_i = 0;
    check({tag, "_busy"}, busy_o, 1);
    if (!donly) check({tag, "_first_vld"}, sv_valid_o, 1);
    while (1) begin
      if (done_o) begin
        check({tag, "_busy_at_done"}, busy_o, 0);
        break;
      end
      if (cyc > 400) begin
        check({tag, "_timeout"}, done_o, 1);
        break;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sv_ready_i = rdy;
      #1;
      if (stalled) begin
        check({tag, "_hold_vld"}, sv_valid_o, 1);
        check({tag, "_hold_addr"}, sv_addr_o, p_addr);
        check({tag, "_hold_data"}, sv_data_o, p_data);
      end
      stalled = 0;
      if (sv_valid_o) begin
        if (rdy) begin
          beats++;
          a = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          check({tag, "_addr"}, sv_addr_o, a);
          if (a >= 0) check({tag, "_data"}, sv_data_o, m_regs[a]);
          check({tag, "_last"}, sv_last_o, (exp_q.size() == 0));
          m_dirty[sv_addr_o] = 1'b0;
        end else begin
          stalled = 1;
          p_addr  = sv_addr_o;
          p_data  = sv_data_o;
        end
      end
      cyc++;
      @(negedge clk_i);
    end
    sv_ready_i = 0;
    check({tag, "_beats"}, beats, n_exp);
    @(negedge clk_i);
    check({tag, "_done_single"}, done_o, 0);
    check({tag, "_dirty_after"}, dirty_o, m_dirty);
  endtask

  // Restore 0x40000000+i into reg i with random valid gaps; one pipeline write is attempted mid-way.
  task automatic do_restore(input string tag);
    int i = 0;
    int cyc = 0;
    bit drop_pend = 0;
    bit dropped_once = 0;
    @(negedge clk_i);
    we_i = 0; rs_valid_i = 0; restore_start_i = 1;
    @(negedge clk_i);
    restore_start_i = 0;
    while (1) begin
      check({tag, "_wr_drop"}, wr_drop_o, drop_pend);
      if (done_o) begin
        check({tag, "_busy_at_done"}, busy_o, 0);
        break;
      end
      if (cyc > 500) begin
        check({tag, "_timeout"}, done_o, 1);
        break;
      end
      check({tag, "_rdy"}, rs_ready_o, 1);
      drop_pend = 0;
      we_i = 0;
      if (i == 10 && !dropped_once) begin
        we_i = 1; w_addr_i = ADDR_W'($urandom); w_data_i = $urandom;
        drop_pend = 1; dropped_once = 1;
      end
      rs_valid_i = (i < DEPTH) && ($urandom_range(0, 2) != 0);
      rs_data_i  = 32'h4000_0000 + i;
      if (rs_valid_i) begin
        m_regs[i]  = rs_data_i;
        m_dirty[i] = 1'b0;
        i++;
      end
      cyc++;
      @(negedge clk_i);
    end
    rs_valid_i = 0; we_i = 0;
    check({tag, "_beats"}, i, DEPTH);
    @(negedge clk_i);
    check({tag, "_done_single"}, done_o, 0);
    check({tag, "_dirty_after"}, dirty_o, m_dirty);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; clk_en_i = 1; we_i = 0; w_addr_i = '0; w_data_i = '0; rd_addr_i = '0;
    save_start_i = 0; save_dirty_only_i = 0; restore_start_i = 0;
    sv_ready_i = 0; rs_valid_i = 0; rs_data_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_svvld", sv_valid_o, 0);
    check("rst_rsrdy", rs_ready_o, 0);
    check("rst_dirty", dirty_o, 0);
    rst_i = 0;

    // Reset contents on all ports.
    rw_cycle(0, '0, '0, 0);
    rw_cycle(0, '0, '0, 5);
    rw_cycle(0, '0, '0, 31);
    check("post_rst_dirty", dirty_o, 0);

    // Write with same-cycle bypass, then the dirty bit.
    rw_cycle(1, 7, 32'h3F80_0000, 7);
    @(negedge clk_i);
    we_i = 0;
    check("dirty7", dirty_o[7], 1);
    check("dirty_vec", dirty_o, m_dirty);

    // Random writes, then full save with toggling ready.
    for (int n = 0; n < 40; n++)
      rw_cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, -1);
    do_save(0, 1, "fsave");

    // Dirty-only save of regs 2 and 30.
    rw_cycle(1, 2, 32'hC0DE_0002, -1);
    rw_cycle(1, 30, 32'hC0DE_001E, -1);
    do_save(1, 0, "dsave");

    // Random rounds.
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 20; n++)
        rw_cycle(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom), $urandom, -1);
      do_save(1'($urandom_range(0, 1)), 2, "rsave");
    end
    // Dirty-only save with nothing dirty: scan only, no beats.
    do_save(1, 2, "esave");

    // Restore with gaps and a dropped write; then read everything back.
    rw_cycle(1, 3, 32'h1111_1111, -1);
    do_restore("rest");
    for (int a = 0; a < DEPTH; a++) rw_cycle(0, '0, '0, a);

    // Both starts together: save wins; then reset mid-save.
    @(negedge clk_i);
    we_i = 0; save_start_i = 1; restore_start_i = 1; save_dirty_only_i = 0;
    @(negedge clk_i);
    save_start_i = 0; restore_start_i = 0;
    check("both_busy", busy_o, 1);
    check("both_svvld", sv_valid_o, 1);
    check("both_rsrdy", rs_ready_o, 0);
    check("both_addr0", sv_addr_o, 0);
    sv_ready_i = 1;
    repeat (4) @(negedge clk_i);
    check("mid_addr4", sv_addr_o, 4);
    check("mid_data4", sv_data_o, m_regs[4]);
    #2 rst_i = 1;
    #1;
    model_reset();
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_drop", wr_drop_o, 0);
    check("arst_svvld", sv_valid_o, 0);
    check("arst_last", sv_last_o, 0);
    check("arst_rsrdy", rs_ready_o, 0);
    check("arst_data", rd_data_o, 0);
    sv_ready_i = 0;
    repeat (2) begin
      @(negedge clk_i);
      check("arst_no_done", done_o, 0);
    end
    rst_i = 0;

    // Clock enable low: a write is not taken.
    @(negedge clk_i);
    clk_en_i = 0; we_i = 1; w_addr_i = 9; w_data_i = 32'h1234_5678;
    @(negedge clk_i);
    clk_en_i = 1; we_i = 0;
    check("cken_dirty", dirty_o, 0);
    rw_cycle(0, '0, '0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
